// File: rtl/combat_event_if.sv
// Frame-rate collision bundle between the game logic and the combat event generator.
// Slave side consumes positions/flags and drives the event pulses.
interface combat_event_if #(
    parameter int NUM_ENEMIES = 4
);
    logic                      playing;
    logic [9:0]                player_x;
    logic [9:0]                player_y;
    logic [NUM_ENEMIES-1:0]    enemy_alive;
    logic [10*NUM_ENEMIES-1:0] enemy_x;
    logic [10*NUM_ENEMIES-1:0] enemy_y;
    logic                      pbullet_active;
    logic [9:0]                pbullet_x;
    logic [9:0]                pbullet_y;
    logic [NUM_ENEMIES-1:0]    ebullet_active;
    logic [10*NUM_ENEMIES-1:0] ebullet_x;
    logic [10*NUM_ENEMIES-1:0] ebullet_y;
    logic                      scoring;
    logic                      hit;
    logic [NUM_ENEMIES-1:0]    enemy_kill;
    logic                      pbullet_clear;
    logic [NUM_ENEMIES-1:0]    ebullet_clear;
    logic                      invuln;

    modport master (
        output playing, player_x, player_y,
        output enemy_alive, enemy_x, enemy_y,
        output pbullet_active, pbullet_x, pbullet_y,
        output ebullet_active, ebullet_x, ebullet_y,
        input  scoring, hit, enemy_kill,
        input  pbullet_clear, ebullet_clear, invuln
    );

    modport slave (
        input  playing, player_x, player_y,
        input  enemy_alive, enemy_x, enemy_y,
        input  pbullet_active, pbullet_x, pbullet_y,
        input  ebullet_active, ebullet_x, ebullet_y,
        output scoring, hit, enemy_kill,
        output pbullet_clear, ebullet_clear, invuln
    );
endinterface

// File: rtl/combat_event_gen.sv
// Per-frame bullet/tank collision events with one-frame registered pulses.
// Define COMBAT_INVULN_EN to add the post-hit invulnerability window.
module combat_event_gen #(
    parameter int NUM_ENEMIES   = 4,
    parameter int TANK_SIZE     = 16,
    parameter int BULLET_SIZE   = 4,
    parameter int INVULN_FRAMES = 60
) (
    input  logic          frame_clk,
    input  logic          Reset,
    combat_event_if.slave bus
);
    localparam logic [10:0] TS = 11'(TANK_SIZE);
    localparam logic [10:0] BS = 11'(BULLET_SIZE);

`ifdef COMBAT_INVULN_EN
    typedef enum logic [1:0] {S_DIS, S_ACT, S_INV} state_t;
    localparam logic [7:0] INV_N = 8'(INVULN_FRAMES);
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
`else
    typedef enum logic [0:0] {S_DIS, S_ACT} state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_scoring;
    logic                   r_hit;
    logic                   r_pclear;
    logic                   r_invuln;
    logic [NUM_ENEMIES-1:0] r_kill;
    logic [NUM_ENEMIES-1:0] r_eclear;
    logic [NUM_ENEMIES-1:0] w_kill;
    logic [NUM_ENEMIES-1:0] w_eclear;
    logic                   w_found;
    logic                   w_any_eb;
    logic                   w_en;
    logic                   w_hit;
    logic                   w_invuln;

    // 11-bit compare so boxes touching the right/bottom edge never wrap
    function automatic logic f_ovl(
        input logic [9:0]  ax,
        input logic [9:0]  ay,
        input logic [10:0] sa,
        input logic [9:0]  bx,
        input logic [9:0]  by,
        input logic [10:0] sb
    );
        return ({1'b0, ax} < {1'b0, bx} + sb) &&
               ({1'b0, bx} < {1'b0, ax} + sa) &&
               ({1'b0, ay} < {1'b0, by} + sb) &&
               ({1'b0, by} < {1'b0, ay} + sa);
    endfunction

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_DIS;
            r_scoring <= 1'b0;
            r_hit     <= 1'b0;
            r_pclear  <= 1'b0;
            r_invuln  <= 1'b0;
            r_kill    <= '0;
            r_eclear  <= '0;
`ifdef COMBAT_INVULN_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_scoring <= w_en && w_found;
            r_pclear  <= w_en && w_found;
            r_kill    <= w_en ? w_kill : '0;
            r_eclear  <= w_en ? w_eclear : '0;
            r_hit     <= w_hit;
            r_invuln  <= w_invuln;
`ifdef COMBAT_INVULN_EN
            r_cnt     <= w_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
`ifdef COMBAT_INVULN_EN
        w_cnt_nxt = '0;
`endif
        if (!bus.playing) begin
            w_state_nxt = S_DIS;
        end else begin
            unique case (r_state)
                S_DIS: w_state_nxt = S_ACT;
`ifdef COMBAT_INVULN_EN
                S_ACT: begin
                    if (w_any_eb) begin
                        w_state_nxt = S_INV;
                        w_cnt_nxt   = INV_N;
                    end
                end
                S_INV: begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = S_ACT;
                        w_cnt_nxt   = '0;
                    end
                end
`else
                S_ACT: w_state_nxt = S_ACT;
`endif
                default: w_state_nxt = S_DIS;
            endcase
        end
    end

    always_comb begin
        w_kill   = '0;
        w_eclear = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (!w_found && bus.pbullet_active && bus.enemy_alive[i] &&
                f_ovl(bus.pbullet_x, bus.pbullet_y, BS,
                      bus.enemy_x[10*i +: 10], bus.enemy_y[10*i +: 10], TS)) begin
                w_kill[i] = 1'b1;
                w_found   = 1'b1;
            end
            w_eclear[i] = bus.ebullet_active[i] &&
                f_ovl(bus.ebullet_x[10*i +: 10], bus.ebullet_y[10*i +: 10], BS,
                      bus.player_x, bus.player_y, TS);
        end
        w_any_eb = |w_eclear;
        w_en     = bus.playing && (r_state != S_DIS);
        w_hit    = w_en && w_any_eb && (r_state == S_ACT);
`ifdef COMBAT_INVULN_EN
        w_invuln = (w_state_nxt == S_INV);
`else
        w_invuln = 1'b0;
`endif
    end

    assign bus.scoring       = r_scoring;
    assign bus.hit           = r_hit;
    assign bus.enemy_kill    = r_kill;
    assign bus.pbullet_clear = r_pclear;
    assign bus.ebullet_clear = r_eclear;
    assign bus.invuln        = r_invuln;
endmodule

// File: tb/tb_combat_event_gen.sv
// Directed and random frames against a frame-level reference model
// of the combat event generator.
module tb_combat_event_gen;
    localparam int NE = 4;
    localparam int TS = 16;
    localparam int BS = 4;
    localparam int IF = 3;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_total   = 0;
    int   n_pass    = 0;
    int   n_fail    = 0;

    combat_event_if #(.NUM_ENEMIES(NE)) bus ();

    combat_event_gen #(
        .NUM_ENEMIES(NE), .TANK_SIZE(TS),
        .BULLET_SIZE(BS), .INVULN_FRAMES(IF)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 frame_clk = ~frame_clk;

    bit          m_on;
    int          m_left;
    logic [NE-1:0] e_kill, e_ec;
    logic        e_sc, e_hit, e_pc, e_inv;

    function automatic bit ovl(input int ax, input int ay, input int sa,
                               input int bx, input int by, input int sb);
        return ax < bx + sb && bx < ax + sa && ay < by + sb && by < ay + sa;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        e_kill = '0; e_ec = '0;
        e_sc = 0; e_hit = 0; e_pc = 0;
        if (!bus.playing) begin
            m_on = 0; m_left = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (bus.pbullet_active && bus.enemy_alive[i] && !e_sc &&
                    ovl(bus.pbullet_x, bus.pbullet_y, BS,
                        bus.enemy_x[10*i +: 10], bus.enemy_y[10*i +: 10], TS)) begin
                    e_kill[i] = 1; e_sc = 1; e_pc = 1;
                end
                e_ec[i] = bus.ebullet_active[i] &&
                    ovl(bus.ebullet_x[10*i +: 10], bus.ebullet_y[10*i +: 10], BS,
                        bus.player_x, bus.player_y, TS);
            end
`ifdef COMBAT_INVULN_EN
            if (|e_ec && m_left == 0) begin
                e_hit = 1; m_left = IF;
            end else if (m_left > 0) begin
                m_left--;
            end
`else
            e_hit = |e_ec;
`endif
        end
        e_inv = (m_left > 0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".kill"},    bus.enemy_kill,    e_kill);
        chk({tag, ".scoring"}, bus.scoring,       e_sc);
        chk({tag, ".pclear"},  bus.pbullet_clear, e_pc);
        chk({tag, ".eclear"},  bus.ebullet_clear, e_ec);
        chk({tag, ".hit"},     bus.hit,           e_hit);
        chk({tag, ".invuln"},  bus.invuln,        e_inv);
    endtask

    task automatic check_zero(input string tag);
        e_kill = '0; e_ec = '0;
        e_sc = 0; e_hit = 0; e_pc = 0; e_inv = 0;
        check_all(tag);
    endtask

    task automatic frame(input string tag);
        model_step();
        @(posedge frame_clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input bit play);
        bus.playing        = play;
        bus.player_x       = 10'd500;
        bus.player_y       = 10'd500;
        bus.enemy_alive    = '0;
        bus.enemy_x        = '0;
        bus.enemy_y        = '0;
        bus.pbullet_active = 0;
        bus.pbullet_x      = '0;
        bus.pbullet_y      = '0;
        bus.ebullet_active = '0;
        bus.ebullet_x      = '0;
        bus.ebullet_y      = '0;
    endtask

    task automatic put_enemy(input int i, input int x, input int y);
        bus.enemy_x[10*i +: 10] = 10'(x);
        bus.enemy_y[10*i +: 10] = 10'(y);
    endtask

    task automatic put_eb(input int i, input int x, input int y);
        bus.ebullet_x[10*i +: 10] = 10'(x);
        bus.ebullet_y[10*i +: 10] = 10'(y);
    endtask

    int px, py;

    initial begin
        m_on = 0; m_left = 0;
        idle(1'b1);
        #12;
        check_zero("reset");
        Reset = 0;
        frame("enable");

        // two alive enemies under the bullet: lowest slot is the victim
        bus.pbullet_active = 1;
        bus.pbullet_x = 10'd100; bus.pbullet_y = 10'd100;
        bus.enemy_alive = 4'b0011;
        put_enemy(0, 98, 98);
        put_enemy(1, 100, 100);
        frame("kill");
        chk("kill.onehot", bus.enemy_kill, 4'b0001);
        idle(1'b1);
        frame("kill.after");

        // dead slot under the bullet yields nothing
        bus.pbullet_active = 1;
        bus.pbullet_x = 10'd100; bus.pbullet_y = 10'd100;
        put_enemy(2, 100, 100);
        frame("deadslot");

        // two enemy bullets on the player, held for five frames
        idle(1'b1);
        bus.player_x = 10'd200; bus.player_y = 10'd200;
        bus.ebullet_active = 4'b0101;
        put_eb(0, 202, 202);
        put_eb(2, 210, 210);
        frame("ehit");
        chk("ehit.hit", bus.hit, 1'b1);
        chk("ehit.clear", bus.ebullet_clear, 4'b0101);
        for (int k = 0; k < 4; k++) frame("hold");
        bus.ebullet_active = '0;
        for (int k = 0; k < 4; k++) frame("drain");

        // kill and hit reported together
        bus.ebullet_active = 4'b0001;
        bus.pbullet_active = 1;
        bus.pbullet_x = 10'd50; bus.pbullet_y = 10'd50;
        bus.enemy_alive = 4'b1000;
        put_enemy(3, 45, 45);
        frame("both");
        chk("both.pair", {bus.scoring, bus.hit}, 2'b11);

        // reset in the middle of an invulnerability window
        idle(1'b1);
        frame("pre_rst");
        Reset = 1;
        #1;
        m_on = 0; m_left = 0;
        check_zero("rst_async");
        @(posedge frame_clk);
        #1;
        check_zero("rst_held");
        Reset = 0;
        bus.player_x = 10'd200; bus.player_y = 10'd200;
        bus.ebullet_active = 4'b0010;
        put_eb(1, 205, 205);
        frame("post_rst1");
        frame("post_rst2");
        chk("post_rst.hit", bus.hit, 1'b1);

        // right-edge boxes must not wrap
        idle(1'b1);
        frame("edge_pre");
        bus.pbullet_active = 1;
        bus.pbullet_x = 10'd1020; bus.pbullet_y = 10'd50;
        bus.enemy_alive = 4'b0001;
        put_enemy(0, 1015, 50);
        frame("edge_hit");
        chk("edge_hit.kill", bus.enemy_kill, 4'b0001);
        bus.pbullet_x = 10'd0;
        frame("edge_miss");
        chk("edge_miss.kill", bus.enemy_kill, 4'b0000);

        for (int f = 0; f < 400; f++) begin
            bus.playing = ($urandom_range(19, 0) != 0);
            px = $urandom_range(900, 60);
            py = $urandom_range(900, 60);
            bus.player_x = 10'(px);
            bus.player_y = 10'(py);
            bus.enemy_alive = 4'($urandom);
            bus.ebullet_active = 4'($urandom) & 4'($urandom);
            bus.pbullet_active = 1'($urandom);
            bus.pbullet_x = 10'(px + int'($urandom_range(40, 0)) - 20);
            bus.pbullet_y = 10'(py + int'($urandom_range(40, 0)) - 20);
            for (int i = 0; i < NE; i++) begin
                put_enemy(i, px + int'($urandom_range(48, 0)) - 24,
                             py + int'($urandom_range(48, 0)) - 24);
                put_eb(i, px + int'($urandom_range(40, 0)) - 20,
                          py + int'($urandom_range(40, 0)) - 20);
            end
            frame("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/combat_event_gen.md
COMBAT_EVENT_GEN -- requirements
Module: combat_event_gen

Interface
REQ-001 Parameter NUM_ENEMIES, default 4, number of enemy tank slots (1-8).
REQ-002 Parameter TANK_SIZE, default 16, tank bounding-box edge in pixels.
REQ-003 Parameter BULLET_SIZE, default 4, bullet bounding-box edge in pixels.
REQ-004 Parameter INVULN_FRAMES, default 60, frames of player invulnerability after a hit (1-255).
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 frame_clk  input  1  clock, one rising edge per video frame.
REQ-007 playing  input  1  game in Playing state; enables event generation.
REQ-008 player_x, player_y  input  10 each  player tank top-left pixel.
REQ-009 enemy_alive  input  NUM_ENEMIES  per-slot enemy tank present.
REQ-010 enemy_x, enemy_y  input  10*NUM_ENEMIES each  packed enemy top-left; slot i at bits [10i+9:10i].
REQ-011 pbullet_active  input  1  player bullet in flight; pbullet_x, pbullet_y input 10 each.
REQ-012 ebullet_active  input  NUM_ENEMIES  per-enemy bullet in flight; ebullet_x, ebullet_y input 10*NUM_ENEMIES each, same packing.
REQ-013 scoring  output  1  one-frame pulse: player destroyed an enemy.
REQ-014 hit  output  1  one-frame pulse: player tank damaged.
REQ-015 enemy_kill  output  NUM_ENEMIES  one-hot one-frame pulse naming destroyed slot.
REQ-016 pbullet_clear  output  1  one-frame pulse: retire player bullet.
REQ-017 ebullet_clear  output  NUM_ENEMIES  one-frame pulses: retire those enemy bullets.
REQ-018 invuln  output  1  level: player currently invulnerable.

Function
REQ-019 All outputs SHALL be registered; inputs sampled at edge k SHALL produce outputs valid from edge k until edge k+1 (latency 1 frame, pulse width 1 frame).
REQ-020 Overlap of box A (ax,ay,size SA) and box B SHALL be ax < bx+SB && bx < ax+SA && same on y, computed in 11-bit unsigned arithmetic (no wrap).
REQ-021 Player kill: if pbullet_active and the bullet overlaps one or more slots with enemy_alive set, the lowest-index such slot SHALL be the victim: enemy_kill bit set, scoring=1, pbullet_clear=1; at most one kill per frame.
REQ-022 Enemy bullet hit: every slot i with ebullet_active[i] overlapping the player box SHALL get ebullet_clear[i]=1, regardless of invulnerability.
REQ-023 FSM states DISABLED, ACTIVE, INVULN; DISABLED->ACTIVE when playing=1; any state->DISABLED when playing=0.
REQ-024 In ACTIVE, any enemy bullet overlap SHALL produce exactly one hit pulse (multiple bullets same frame = one hit), load counter with INVULN_FRAMES, and enter INVULN.
REQ-025 In INVULN, hit SHALL stay 0; counter decrements each edge; hit at edge k SHALL be ignored on edges k+1..k+INVULN_FRAMES and honoured at k+INVULN_FRAMES+1; state returns to ACTIVE when counter reaches 0.
REQ-026 invuln SHALL equal 1 exactly while state is INVULN.
REQ-027 Kill and hit in the same frame SHALL both be reported.
REQ-028 Player bullet overlapping a dead slot (enemy_alive=0) SHALL produce no event.
REQ-029 In DISABLED all pulse outputs SHALL be 0, no clears issued, counter held at 0.
REQ-030 playing dropping during INVULN SHALL abort the window (counter 0, invuln 0 next edge).

Reset
REQ-031 Reset SHALL force state DISABLED, counter 0 and all outputs 0 asynchronously, including mid-window or mid-pulse.
REQ-032 First events after Reset release SHALL require playing=1 sampled, then a collision on a later edge (one frame DISABLED->ACTIVE transition).

Configuration
REQ-033 Macro COMBAT_INVULN_EN: defined -> INVULN state and counter as REQ-024/025; undefined -> no INVULN state, invuln tied 0, every frame with an enemy bullet overlap yields a hit pulse.

Verification
REQ-034 Player bullet at (100,100), enemies 0 and 1 alive at (98,98) and (100,100) -> next frame enemy_kill=0001, scoring=1, pbullet_clear=1, then all 0.
REQ-035 Enemy bullets 0 and 2 overlapping player at (200,200), ACTIVE -> single hit pulse, ebullet_clear=0101, invuln=1.
REQ-036 INVULN_FRAMES=3, overlap held every frame from edge k -> hit at k+1 and again only at k+5 (COMBAT_INVULN_EN); without macro hit every frame.
REQ-037 Kill and hit same edge -> scoring=1 and hit=1 same frame.
REQ-038 Reset asserted during INVULN with counter 2 -> outputs 0 immediately; post-release, playing=1 then collision -> hit pulse two edges later.
REQ-039 Player bullet box x=1020 near tank x=1015 -> overlap detected, no wrap; bullet x=0 vs tank x=1015 -> no event.
